// File: rtl/data_mem_lat_resp.sv
// Data-side memory responder for the LC3 bus with configurable read/write wait states,
// a base-address window and out-of-window error reporting. Requests are strictly serialised.
module data_mem_lat_resp #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                MEM_AW    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h3000,
    parameter int                RD_LAT    = 3,
    parameter int                WR_LAT    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Data_req,
    input  logic              Data_rd,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data,
    output logic              busy,
    output logic              err_oob
);

    localparam int DEPTH = 2 ** MEM_AW;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
    localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    if (MEM_AW > ADDR_W) begin : g_bad_mem_aw
        $error("data_mem_lat_resp: MEM_AW must not exceed ADDR_W");
    end
    if ((longint'(BASE_ADDR) + longint'(DEPTH)) > (longint'(1) << ADDR_W)) begin : g_bad_window
        $error("data_mem_lat_resp: address window wraps past the top of the address space");
    end
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("data_mem_lat_resp: RD_LAT must be in 1..15");
    end
    if (WR_LAT < 1 || WR_LAT > 15) begin : g_bad_wr_lat
        $error("data_mem_lat_resp: WR_LAT must be in 1..15");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [3:0]        lat_q;
    logic              rd_q;
    logic              win_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;
    logic              sel_rd;
    logic [ADDR_W:0]   offset;
    logic              sel_win;
    logic [MEM_AW-1:0] sel_idx;
    logic [3:0]        lat_in;
    logic              accept;
    logic              last_wait;
    logic              fire;

    // In IDLE the live bus is used so a single-cycle latency can complete on the accept edge;
    // afterwards only the captured request is looked at.
    always_comb begin
        sel_addr  = (state == IDLE) ? Data_addr : addr_q;
        sel_din   = (state == IDLE) ? Data_din  : din_q;
        sel_rd    = (state == IDLE) ? Data_rd   : rd_q;
        offset    = {1'b0, sel_addr} - {1'b0, BASE_ADDR};
        sel_win   = (offset < DEPTH_X);
        sel_idx   = offset[MEM_AW-1:0];
        lat_in    = Data_rd ? RD_LAT_C : WR_LAT_C;
        accept    = (state == IDLE) && Data_req;
        last_wait = (state == WAIT) && (cnt == (lat_q - 4'd1));
        fire      = (accept && (lat_in == 4'd1)) || last_wait;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            lat_q <= 4'd0;
            rd_q  <= 1'b0;
            win_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_q <= lat_in;
                        rd_q  <= Data_rd;
                        win_q <= sel_win;
                        cnt   <= 4'd1;
                        state <= (lat_in == 4'd1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (last_wait) begin
                        cnt   <= 4'd0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    cnt   <= 4'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q <= Data_addr;
            din_q  <= Data_din;
        end
    end

    // Out-of-window reads return zero rather than stale data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Data_dout <= '0;
        end else if (fire && sel_rd) begin
            Data_dout <= sel_win ? mem[sel_idx] : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (fire && !sel_rd && sel_win) begin
            mem[sel_idx] <= sel_din;
        end
    end

    assign busy          = (state != IDLE);
    assign complete_data = (state == RESP);
    assign err_oob       = (state == RESP) && !win_q;

endmodule

// File: tb/tb_data_mem_lat_resp.sv
// Scoreboard bench for data_mem_lat_resp: a behavioural model predicts acceptance, completion edge,
// read data and error flag for each request; the monitor compares them as completions appear.
module tb_data_mem_lat_resp;

    localparam int RD_LAT = 3;
    localparam int WR_LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        Data_req = 1'b0;
    logic        Data_rd = 1'b0;
    logic [15:0] Data_addr = 16'h0;
    logic [15:0] Data_din = 16'h0;
    logic [15:0] Data_dout;
    logic        complete_data;
    logic        busy;
    logic        err_oob;

    data_mem_lat_resp dut (
        .clock         (clock),
        .reset         (reset),
        .Data_req      (Data_req),
        .Data_rd       (Data_rd),
        .Data_addr     (Data_addr),
        .Data_din      (Data_din),
        .Data_dout     (Data_dout),
        .complete_data (complete_data),
        .busy          (busy),
        .err_oob       (err_oob)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          edge_n;
        bit          rd;
        bit          oob;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    int          cyc = 0;
    int          m_free = 0;
    int          m_busy_hi = -1;
    int          m_nacc = 0;
    bit          m_last_rd = 1'b1;
    bit          pend = 1'b0;
    int          pend_edge = 0;
    bit          pend_wr_ok = 1'b0;
    logic [7:0]  pend_idx = 8'h0;
    logic [15:0] pend_din = 16'h0;
    logic [15:0] mem_m [256];

    // Reference model: one outstanding request, write committed only when its latency expires.
    always @(posedge clock) begin
        int          lat;
        bit          win;
        logic [15:0] off;
        exp_t        ne;
        cyc++;
        if (reset) begin
            sb.delete();
            pend      = 1'b0;
            m_free    = 0;
            m_busy_hi = -1;
        end else begin
            if (pend && cyc == pend_edge) begin
                if (pend_wr_ok) mem_m[pend_idx] = pend_din;
                pend = 1'b0;
            end
            if (Data_req && cyc >= m_free) begin
                lat       = Data_rd ? RD_LAT : WR_LAT;
                win       = (Data_addr >= 16'h3000) && (Data_addr < 16'h3100);
                off       = Data_addr - 16'h3000;
                ne.edge_n = cyc + lat - 1;
                ne.rd     = Data_rd;
                ne.oob    = !win;
                ne.data   = (Data_rd && win) ? mem_m[off[7:0]] : 16'h0;
                sb.push_back(ne);
                pend       = 1'b1;
                pend_edge  = ne.edge_n;
                pend_wr_ok = !Data_rd && win;
                pend_idx   = off[7:0];
                pend_din   = Data_din;
                m_free     = cyc + lat + 1;
                m_busy_hi  = cyc + lat - 1;
                m_nacc++;
                m_last_rd  = Data_rd;
            end
        end
    end

    always @(negedge clock) begin
        exp_t me;
        if (reset) begin
            chk("rst_complete", complete_data, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_err", err_oob, 1'b0);
            chk("rst_dout", Data_dout, 16'h0);
        end else begin
            chk("busy", busy, cyc <= m_busy_hi);
            if (complete_data) begin
                if (sb.size() == 0) begin
                    chk("spurious_complete", 1, 0);
                end else begin
                    me = sb.pop_front();
                    chk("complete_edge", cyc, me.edge_n);
                    chk("err_oob", err_oob, me.oob);
                    if (me.rd) chk("dout", Data_dout, me.data);
                end
            end else begin
                chk("err_idle", err_oob, 1'b0);
                if (sb.size() != 0 && cyc > sb[0].edge_n) begin
                    chk("missed_complete", cyc, sb[0].edge_n);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input bit rd, input logic [15:0] addr, input logic [15:0] din);
        int n0 = m_nacc;
        bit ok = 1'b0;
        @(negedge clock);
        Data_rd   = rd;
        Data_addr = addr;
        Data_din  = din;
        Data_req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (m_nacc != n0) begin
                ok = 1'b1;
                break;
            end
        end
        Data_req = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;

        // Basic write then read-back with latency check
        issue(1'b0, 16'h3005, 16'hBEEF);
        issue(1'b1, 16'h3005, 16'h0000);
        wait_done();

        // Window edges
        issue(1'b0, 16'h3000, 16'hA5A5);
        issue(1'b0, 16'h30FF, 16'h5A5A);
        issue(1'b1, 16'h3000, 16'h0000);
        issue(1'b1, 16'h30FF, 16'h0000);
        wait_done();

        // Out-of-window read and write; 3100 would alias index 0 if truncated
        issue(1'b1, 16'h2FFF, 16'h0000);
        issue(1'b0, 16'h3100, 16'h1234);
        issue(1'b1, 16'h3000, 16'h0000);
        wait_done();

        // Extra strobes during WAIT/RESP and bus changes after accept
        issue(1'b0, 16'h3040, 16'hC0DE);
        issue(1'b1, 16'h3040, 16'h0000);
        Data_addr = 16'h3000;
        Data_rd   = 1'b0;
        Data_din  = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            Data_req = 1'b1;
            @(posedge clock);
            #1 Data_req = 1'b0;
        end
        wait_done();
        issue(1'b1, 16'h3000, 16'h0000);
        wait_done();

        // Continuous request with alternating direction
        for (int k = 0; k < 4; k++) issue(1'b0, 16'h3020 + 16'(k), 16'h1100 + 16'(k));
        wait_done();
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            Data_req  = 1'b1;
            Data_rd   = !m_last_rd;
            Data_addr = 16'h3020 + 16'(m_nacc % 4);
            Data_din  = 16'($urandom);
        end
        @(negedge clock);
        Data_req = 1'b0;
        wait_done();

        // Reset during WAIT must drop the write
        issue(1'b0, 16'h3010, 16'h0001);
        issue(1'b1, 16'h3010, 16'h0000);
        wait_done();
        issue(1'b0, 16'h3010, 16'hDEAD);
        #1 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_complete", complete_data, 1'b0);
        chk("abort_err", err_oob, 1'b0);
        chk("abort_dout", Data_dout, 16'h0);
        @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        issue(1'b1, 16'h3010, 16'h0000);
        wait_done();

        repeat (3) @(negedge clock);
        chk("leftover", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
